loong_ct_uart_framer: RTL

// - Downstream of LOONG_ENC. Snapshots the 16-nibble ciphertext on a one-cycle valid pulse and packs it into bytes.
// - Streams a framed reply into a uart_tx instance (i_Tx_DV / o_Tx_Active / o_Tx_Done handshake).
// - Frame: HEADER, 8 payload bytes, [checksum], TRAILER. Mirrors the receive-side 0xAA/0xFF framing.

---
 rtl/loong_pkg.sv | 17 +
 rtl/loong_ct_uart_framer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/loong_pkg.sv
// Shared LOONG definitions: framing bytes, nibble array type and framer state encoding.
package loong_pkg;

  localparam int unsigned LOONG_NIBBLES = 16;
  localparam logic [7:0]  LOONG_HDR     = 8'hAA;
  localparam logic [7:0]  LOONG_TRL     = 8'hFF;

  // Ciphertext as produced by LOONG_ENC; element i is nibble i.
  typedef logic [LOONG_NIBBLES-1:0][3:0] loong_nibbles_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } loong_state_e;

endpackage

// File: rtl/loong_ct_uart_framer.sv
// Snapshots a LOONG ciphertext and streams it to uart_tx as HEADER, payload, [checksum], TRAILER.
// Build option: LOONG_TX_CHECKSUM_EN inserts an XOR checksum byte ahead of the trailer.
module loong_ct_uart_framer
  import loong_pkg::*;
#(
  parameter logic [7:0]  HEADER_BYTE  = LOONG_HDR,
  parameter logic [7:0]  TRAILER_BYTE = LOONG_TRL,
  parameter int unsigned NIBBLES      = LOONG_NIBBLES
) (
  input  logic                    clck,
  input  logic                    reset,
  input  logic                    ct_valid,
  input  logic [NIBBLES-1:0][3:0] ciphertext,
  output logic                    tx_dv,
  output logic [7:0]              tx_byte,
  input  logic                    tx_active,
  input  logic                    tx_done,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overrun
);

  localparam int unsigned IDX_W     = 4;
  localparam int unsigned PAY_BYTES = NIBBLES / 2;
`ifdef LOONG_TX_CHECKSUM_EN
  localparam int unsigned LAST = PAY_BYTES + 2;
`else
  localparam int unsigned LAST = PAY_BYTES + 1;
`endif

  loong_state_e              state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [NIBBLES-1:0][3:0]   snap_q, snap_d;
  logic                      tx_dv_q, tx_dv_d;
  logic [7:0]                tx_byte_q, tx_byte_d;
  logic                      busy_q, busy_d;
  logic                      frame_done_q, frame_done_d;
  logic                      overrun_q, overrun_d;
  logic [7:0]                cur_byte;
  logic                      is_payload;
`ifdef LOONG_TX_CHECKSUM_EN
  logic [7:0]                csum_q, csum_d;
`endif

  // Byte selected by idx; anything past the payload (and checksum) is the trailer.
  always_comb begin
    cur_byte   = TRAILER_BYTE;
    is_payload = 1'b0;
    if (idx_q == '0) begin
      cur_byte = HEADER_BYTE;
    end
    for (int unsigned k = 0; k < PAY_BYTES; k++) begin
      if (idx_q == IDX_W'(k + 1)) begin
        cur_byte   = {snap_q[2*k+1], snap_q[2*k]};
        is_payload = 1'b1;
      end
    end
`ifdef LOONG_TX_CHECKSUM_EN
    if (idx_q == IDX_W'(PAY_BYTES + 1)) begin
      cur_byte = csum_q;
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    snap_d       = snap_q;
    tx_dv_d      = 1'b0;
    tx_byte_d    = tx_byte_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
`ifdef LOONG_TX_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    case (state_q)
      IDLE: begin
        if (ct_valid) begin
          snap_d  = ciphertext;
          idx_d   = '0;
`ifdef LOONG_TX_CHECKSUM_EN
          csum_d  = '0;
`endif
          state_d = SEND;
        end
      end
      SEND: begin
        if (!tx_active) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = cur_byte;
`ifdef LOONG_TX_CHECKSUM_EN
          if (is_payload) begin
            csum_d = csum_q ^ cur_byte;
          end
`endif
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (tx_done) begin
          if (idx_q == IDX_W'(LAST)) begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A new ciphertext while a frame is in flight is dropped, including the final tx_done cycle.
    if (ct_valid && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    // busy covers the frame_done cycle and drops on the following one.
    busy_d = (state_d != IDLE) || frame_done_d;
  end

  always_ff @(posedge clck) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      snap_q       <= '0;
      tx_dv_q      <= 1'b0;
      tx_byte_q    <= 8'h00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef LOONG_TX_CHECKSUM_EN
      csum_q       <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      tx_dv_q      <= tx_dv_d;
      tx_byte_q    <= tx_byte_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
`ifdef LOONG_TX_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign tx_dv      = tx_dv_q;
  assign tx_byte    = tx_byte_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule
